tx_dec_formatter: RTL and testbench

Parametrised decimal-ASCII transmit formatter that sits between a core result bus and the UART transmitter. On request it captures a W-bit value, treated as signed or unsigned, and converts it to BCD with a shift-add (double-dabble) engine, so no dividers are used. It then streams the characters to the UART one at a time: optional '-', digits MSB first with leading zeros suppressed, then the configured end-of-line. It generalises the fixed 8-bit signed printer to any width, adds an unsigned mode, a selectable line ending and explicit busy/done handshakes.

---
 rtl/tx_dec_formatter_if.sv | 23 ++
 rtl/tx_dec_formatter.sv | 189 ++++++++++++++++++
 tb/tb_tx_dec_formatter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/tx_dec_formatter_if.sv
// Bus between a result source / UART transmitter pair and the decimal formatter.
// valid/ready: req is a request pulse taken only while busy=0; tx_start is a one-cycle strobe answered later by tx_done_tick.
interface tx_dec_formatter_if #(
    parameter int W = 8
);
    logic [W-1:0] value;
    logic         req;
    logic         tx_done_tick;
    logic [7:0]   d_in;
    logic         tx_start;
    logic         busy;
    logic         done;

    modport master (
        output value, req, tx_done_tick,
        input  d_in, tx_start, busy, done
    );

    modport slave (
        input  value, req, tx_done_tick,
        output d_in, tx_start, busy, done
    );
endinterface

// File: rtl/tx_dec_formatter.sv
// Decimal-ASCII transmit formatter: double-dabble binary-to-BCD conversion, then
// '-', digits (leading zeros suppressed) and an optional line ending to a UART.
module tx_dec_formatter #(
    parameter int W      = 8,
    parameter int NDIG   = 3,
    parameter int SIGNED = 1,
    parameter int EOL    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    tx_dec_formatter_if.slave     bus,
    output logic [2:0]            dbg_state_o
);

    localparam int CW = $clog2(W) + 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int BW = 4 * NDIG;

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_SIGN, S_DIGIT, S_EOL1, S_EOL2, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            neg_q, neg_d;
    logic [W-1:0]    mag_q, mag_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      d_in_q, d_in_d;
    logic            tx_start_q, tx_start_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   bcd_shift;
    logic [IW-1:0]   hi_idx;
    logic            neg_in;
    logic [W-1:0]    mag_in;
    logic            tick_ok;

    function automatic logic [7:0] digit_char(input logic [BW-1:0] b, input logic [IW-1:0] i);
        logic [BW-1:0] s;
        s = b >> (4 * i);
        return {4'h3, s[3:0]};
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next magnitude bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[BW-2:0], mag_q[W-1]};
        hi_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_shift[4*i +: 4] != 4'd0) hi_idx = IW'(i);
        end
    end

    // W-bit modular negate yields 2^(W-1) for the most negative input, i.e. the
    // W+1-bit magnitude with its always-zero top bit dropped.
    assign neg_in  = (SIGNED != 0) ? bus.value[W-1] : 1'b0;
    assign mag_in  = neg_in ? (~bus.value + 1'b1) : bus.value;
    assign tick_ok = bus.tx_done_tick & ~tx_start_q;

    always_comb begin
        state_d    = state_q;
        neg_d      = neg_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        d_in_d     = d_in_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    neg_d   = neg_in;
                    mag_d   = mag_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = bcd_shift;
                mag_d = {mag_q[W-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    idx_d      = hi_idx;
                    tx_start_d = 1'b1;
                    if (neg_q) begin
                        d_in_d  = 8'h2D;
                        state_d = S_SIGN;
                    end else begin
                        d_in_d  = digit_char(bcd_shift, hi_idx);
                        state_d = S_DIGIT;
                    end
                end
            end
            S_SIGN: begin
                if (tick_ok) begin
                    d_in_d     = digit_char(bcd_q, idx_q);
                    tx_start_d = 1'b1;
                    state_d    = S_DIGIT;
                end
            end
            S_DIGIT: begin
                if (tick_ok) begin
                    if (idx_q != '0) begin
                        idx_d      = idx_q - IW'(1);
                        d_in_d     = digit_char(bcd_q, idx_q - IW'(1));
                        tx_start_d = 1'b1;
                    end else if (EOL == 2) begin
                        d_in_d     = 8'h0D;
                        tx_start_d = 1'b1;
                        state_d    = S_EOL1;
                    end else if (EOL == 1) begin
                        d_in_d     = 8'h0A;
                        tx_start_d = 1'b1;
                        state_d    = S_EOL1;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_EOL1: begin
                if (tick_ok) begin
                    if (EOL == 2) begin
                        d_in_d     = 8'h0A;
                        tx_start_d = 1'b1;
                        state_d    = S_EOL2;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_EOL2: begin
                if (tick_ok) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            neg_q      <= 1'b0;
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            d_in_q     <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            neg_q      <= neg_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            d_in_q     <= d_in_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.d_in     = d_in_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_tx_dec_formatter.sv
// Directed bench for tx_dec_formatter: three configurations share clock and reset,
// a UART model answers each tx_start with tx_done_tick ten cycles later.
module tb_tx_dec_formatter;

    logic        clk = 1'b0;
    logic        reset;
    int          sel;
    logic [15:0] val_v;
    logic        req_v;
    logic        tick_v;
    int          checks = 0;
    int          passes = 0;
    logic [7:0]  exp_q[$];

    logic [7:0]  cur_d_in;
    logic        cur_tx_start, cur_busy, cur_done;
    logic [2:0]  st_8s, st_8u, st_16;

    always #5 clk = ~clk;

    tx_dec_formatter_if #(.W(8))  if8s ();
    tx_dec_formatter_if #(.W(8))  if8u ();
    tx_dec_formatter_if #(.W(16)) if16 ();

    assign if8s.value = val_v[7:0];
    assign if8s.req = req_v && (sel == 0);
    assign if8s.tx_done_tick = tick_v && (sel == 0);
    assign if8u.value = val_v[7:0];
    assign if8u.req = req_v && (sel == 1);
    assign if8u.tx_done_tick = tick_v && (sel == 1);
    assign if16.value = val_v;
    assign if16.req = req_v && (sel == 2);
    assign if16.tx_done_tick = tick_v && (sel == 2);

    tx_dec_formatter #(.W(8), .NDIG(3), .SIGNED(1), .EOL(2)) u_8s (
        .clk(clk), .reset(reset), .bus(if8s), .dbg_state_o(st_8s));
    tx_dec_formatter #(.W(8), .NDIG(3), .SIGNED(0), .EOL(1)) u_8u (
        .clk(clk), .reset(reset), .bus(if8u), .dbg_state_o(st_8u));
    tx_dec_formatter #(.W(16), .NDIG(5), .SIGNED(1), .EOL(0)) u_16 (
        .clk(clk), .reset(reset), .bus(if16), .dbg_state_o(st_16));

    always_comb begin
        case (sel)
            1: begin cur_d_in = if8u.d_in; cur_tx_start = if8u.tx_start; cur_busy = if8u.busy; cur_done = if8u.done; end
            2: begin cur_d_in = if16.d_in; cur_tx_start = if16.tx_start; cur_busy = if16.busy; cur_done = if16.done; end
            default: begin cur_d_in = if8s.d_in; cur_tx_start = if8s.tx_start; cur_busy = if8s.busy; cur_done = if8s.done; end
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // disturb: 0 none, 1 re-request with new value at 2nd char, 2 spurious tick during conversion
    task automatic run_print(input int s, input logic [15:0] v, input int eolm, input string digits, input int disturb);
        int cyc, first_start, nchars, cnt, last_tick, done_cyc, wexp;
        bit done_seen, stable_ok, gap_ok, waiting, idle_ok;
        logic [7:0] held, want, ch;
        sel = s;
        wexp = (s == 2) ? 16 : 8;
        exp_q.delete();
        for (int i = 0; i < digits.len(); i++) begin
            ch = digits[i];
            exp_q.push_back(ch);
        end
        if (eolm == 2) exp_q.push_back(8'h0D);
        if (eolm >= 1) exp_q.push_back(8'h0A);
        first_start = -1; nchars = 0; cnt = 0; last_tick = -1; done_cyc = -1;
        done_seen = 0; stable_ok = 1; gap_ok = 1; waiting = 0; idle_ok = 1; held = 8'h00;
        val_v = v; req_v = 1'b1; tick_v = 1'b0;
        checks++;
        if (cur_busy !== 1'b0) $display("FAIL %s busy_before_accept: got %b want 0", digits, cur_busy);
        else passes++;
        step(); cyc = 1; req_v = 1'b0;
        checks++;
        if (cur_busy !== 1'b1) $display("FAIL %s busy_after_accept: got %b want 1", digits, cur_busy);
        else passes++;
        while (!done_seen && cyc < 400) begin
            tick_v = 1'b0; req_v = 1'b0;
            if (disturb == 2 && cyc == 3) tick_v = 1'b1;
            if (cur_tx_start === 1'b1) begin
                nchars++;
                if (first_start < 0) first_start = cyc;
                else if (cyc != last_tick + 1) gap_ok = 0;
                checks++;
                if (exp_q.size() == 0) $display("FAIL %s extra_char: got %h want none", digits, cur_d_in);
                else begin
                    want = exp_q.pop_front();
                    if (cur_d_in !== want) $display("FAIL %s char%0d: got %h want %h", digits, nchars, cur_d_in, want);
                    else passes++;
                end
                held = cur_d_in; cnt = 10; waiting = 1;
                if (disturb == 1 && nchars == 2) begin req_v = 1'b1; val_v = ~v; end
            end else if (waiting) begin
                if (cur_d_in !== held) stable_ok = 0;
                cnt--;
                if (cnt == 0) begin tick_v = 1'b1; last_tick = cyc; waiting = 0; end
            end
            if (cur_done === 1'b1) begin
                done_seen = 1; done_cyc = cyc;
                checks++;
                if (cur_busy !== 1'b0) $display("FAIL %s busy_at_done: got %b want 0", digits, cur_busy);
                else passes++;
            end
            if (!done_seen) begin step(); cyc++; end
        end
        checks++;
        if (!done_seen) $display("FAIL %s done_timeout: got no done want done within 400 cycles", digits);
        else if (done_cyc != last_tick + 1) $display("FAIL %s done_timing: got cycle %0d want %0d", digits, done_cyc, last_tick + 1);
        else passes++;
        checks++;
        if (first_start != wexp + 1) $display("FAIL %s first_start_cycle: got %0d want %0d", digits, first_start, wexp + 1);
        else passes++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL %s missing_chars: got %0d missing want 0", digits, exp_q.size());
        else passes++;
        checks++;
        if (!stable_ok || !gap_ok) $display("FAIL %s hold_and_gap: got stable=%0b gap=%0b want 1 1", digits, stable_ok, gap_ok);
        else passes++;
        tick_v = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (cur_busy !== 1'b0 || cur_done !== 1'b0 || cur_tx_start !== 1'b0) idle_ok = 0;
        end
        checks++;
        if (!idle_ok) $display("FAIL %s idle_after_done: got activity want quiet", digits);
        else passes++;
    endtask

    task automatic test_reset();
        bit ok;
        reset = 1'b1; req_v = 1'b0; tick_v = 1'b0; val_v = '0; sel = 0;
        repeat (3) step();
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            ok = (cur_d_in === 8'h00) && (cur_tx_start === 1'b0) && (cur_busy === 1'b0) && (cur_done === 1'b0);
            checks++;
            if (!ok) $display("FAIL reset_dut%0d: got d_in=%h start=%b busy=%b done=%b want 00 0 0 0",
                              s, cur_d_in, cur_tx_start, cur_busy, cur_done);
            else passes++;
        end
        reset = 1'b0; sel = 0;
        step();
    endtask

    task automatic test_signed_basic();
        run_print(0, 16'd123, 2, "123", 0);
    endtask

    task automatic test_signed_edges();
        run_print(0, 16'h0080, 2, "-128", 0);
        run_print(0, 16'h00FF, 2, "-1", 0);
        run_print(0, 16'h0000, 2, "0", 0);
    endtask

    task automatic test_unsigned();
        run_print(1, 16'h00FF, 1, "255", 0);
        run_print(1, 16'd7, 1, "7", 0);
        run_print(1, 16'd100, 1, "100", 0);
    endtask

    task automatic test_wide();
        run_print(2, 16'h8000, 0, "-32768", 0);
        run_print(2, 16'd40, 0, "40", 0);
    endtask

    task automatic test_handshake();
        run_print(0, 16'd57, 2, "57", 1);
        run_print(0, 16'h00FB, 2, "-5", 2);
    endtask

    task automatic test_reset_abort();
        int nst, cnt;
        bit quiet;
        sel = 0; nst = 0; cnt = 0; quiet = 1;
        val_v = 16'd123; req_v = 1'b1; tick_v = 1'b0;
        step(); req_v = 1'b0;
        for (int k = 0; k < 200 && nst < 2; k++) begin
            tick_v = 1'b0;
            if (cur_tx_start === 1'b1) begin nst++; cnt = 10; end
            else if (cnt > 0) begin cnt--; if (cnt == 0) tick_v = 1'b1; end
            if (nst < 2) step();
        end
        checks++;
        if (nst != 2 || cur_d_in !== 8'h32) $display("FAIL abort_second_char: got n=%0d d_in=%h want 2 32", nst, cur_d_in);
        else passes++;
        tick_v = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (cur_d_in !== 8'h00 || cur_tx_start !== 1'b0 || cur_busy !== 1'b0)
            $display("FAIL abort_reset_state: got d_in=%h start=%b busy=%b want 00 0 0", cur_d_in, cur_tx_start, cur_busy);
        else passes++;
        tick_v = 1'b1;
        step();
        tick_v = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (cur_tx_start !== 1'b0 || cur_busy !== 1'b0 || cur_d_in !== 8'h00) quiet = 0;
            step();
        end
        checks++;
        if (!quiet) $display("FAIL abort_late_tick: got output activity want none");
        else passes++;
        run_print(0, 16'd42, 2, "42", 0);
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_signed_edges();
        test_unsigned();
        test_wide();
        test_handshake();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
